// File: rtl/bcd_pkg.sv
// Shared types and constants for the shared binary-to-BCD converter.
package bcd_pkg;
   localparam int DIGIT_W = 4;
   localparam logic [3:0] BCD_BLANK = 4'hF;

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   // Smallest digit count whose decimal range covers 2^width - 1.
   function automatic int min_digits(input int width);
      longint max_val;
      longint pow10;
      int d;
      max_val = (longint'(1) << width) - 1;
      d = 1;
      pow10 = 10;
      while (pow10 <= max_val) begin
         pow10 = pow10 * 10;
         d++;
      end
      return d;
   endfunction
endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every digit >= 5, then shift the whole register left.
module bcd_dabble_step
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic [DIGIT_W*DIGITS+WIDTH-1:0] din,
   output logic [DIGIT_W*DIGITS+WIDTH-1:0] dout
);
   logic [DIGIT_W*DIGITS+WIDTH-1:0] adj;

   always_comb begin
      adj = din;
      for (int i = 0; i < DIGITS; i++) begin
         if (din[WIDTH+DIGIT_W*i +: DIGIT_W] >= 4'd5)
            adj[WIDTH+DIGIT_W*i +: DIGIT_W] = din[WIDTH+DIGIT_W*i +: DIGIT_W] + 4'd3;
      end
      dout = adj << 1;
   end
endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin shared iterative BCD converter for two requesters.
// Define BCD_LEADING_ZERO_BLANK_EN to blank leading-zero tens/hundreds digits with BCD_BLANK.
module bcd_conv_arbiter
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_req0_valid,
   input  logic [WIDTH-1:0] i_req0_val,
   output logic             o_req0_ready,
   input  logic             i_req1_valid,
   input  logic [WIDTH-1:0] i_req1_val,
   output logic             o_req1_ready,
   output logic             o_res_valid,
   input  logic             i_res_ready,
   output logic             o_res_id,
   output logic [3:0]       o_ones,
   output logic [3:0]       o_tens,
   output logic [3:0]       o_hundreds,
   output logic             o_busy
);
   localparam int BCD_W = DIGIT_W * DIGITS;
   localparam int SR_W  = BCD_W + WIDTH;
   localparam int CNT_W = $clog2(WIDTH + 1);

   if (DIGITS < min_digits(WIDTH)) begin : g_param_check
      $error("bcd_conv_arbiter: DIGITS too small for WIDTH");
   end

   state_t            state, state_nxt;
   logic [SR_W-1:0]   sreg, sreg_step;
   logic [CNT_W-1:0]  cnt;
   logic              last_grant, gnt_id, accept, res_id;
   logic [3:0]        ones, tens, hund;
   logic [BCD_W-1:0]  bcd_nxt;
   logic [3:0]        raw_o, raw_t, raw_h, nxt_t, nxt_h;

   bcd_dabble_step #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_step (
      .din  (sreg),
      .dout (sreg_step)
   );

   // On a tie the requester that did not win last time is granted.
   always_comb begin
      if (i_req0_valid && i_req1_valid) gnt_id = ~last_grant;
      else                              gnt_id = ~i_req0_valid;
   end

   assign o_req0_ready = (state == IDLE) && i_req0_valid && !gnt_id;
   assign o_req1_ready = (state == IDLE) && i_req1_valid && gnt_id;
   assign accept       = o_req0_ready || o_req1_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept) state_nxt = CONV;
         CONV:    if (cnt == CNT_W'(1)) state_nxt = DONE;
         DONE:    if (i_res_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Digits as they stand after the final step, taken from the step output.
   assign bcd_nxt = sreg_step[SR_W-1 -: BCD_W];
   assign raw_o   = bcd_nxt[3:0];
   if (DIGITS > 1) begin : g_tens
      assign raw_t = bcd_nxt[7:4];
   end else begin : g_no_tens
      assign raw_t = 4'd0;
   end
   if (DIGITS > 2) begin : g_hund
      assign raw_h = bcd_nxt[11:8];
   end else begin : g_no_hund
      assign raw_h = 4'd0;
   end

`ifdef BCD_LEADING_ZERO_BLANK_EN
   assign nxt_h = (raw_h == 4'd0) ? BCD_BLANK : raw_h;
   assign nxt_t = (raw_h == 4'd0 && raw_t == 4'd0) ? BCD_BLANK : raw_t;
`else
   assign nxt_h = raw_h;
   assign nxt_t = raw_t;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sreg       <= '0;
         cnt        <= '0;
         last_grant <= 1'b1;
         res_id     <= 1'b0;
         ones       <= 4'd0;
         tens       <= 4'd0;
         hund       <= 4'd0;
      end else begin
         unique case (state)
            IDLE: if (accept) begin
               sreg       <= {{BCD_W{1'b0}}, (gnt_id ? i_req1_val : i_req0_val)};
               res_id     <= gnt_id;
               last_grant <= gnt_id;
               cnt        <= CNT_W'(WIDTH);
            end
            CONV: begin
               sreg <= sreg_step;
               cnt  <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  ones <= raw_o;
                  tens <= nxt_t;
                  hund <= nxt_h;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_res_valid = (state == DONE);
   assign o_busy      = (state != IDLE);
   assign o_res_id    = res_id;
   assign o_ones      = ones;
   assign o_tens      = tens;
   assign o_hundreds  = hund;
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed self-checking bench for bcd_conv_arbiter (WIDTH=8, DIGITS=3).
module tb_bcd_conv_arbiter;
   localparam int WIDTH = 8;
`ifdef BCD_LEADING_ZERO_BLANK_EN
   localparam logic [3:0] ZB = 4'hF;
`else
   localparam logic [3:0] ZB = 4'h0;
`endif

   logic             i_clk = 1'b0;
   logic             i_rst = 1'b1;
   logic             i_req0_valid = 1'b0, i_req1_valid = 1'b0, i_res_ready = 1'b0;
   logic [WIDTH-1:0] i_req0_val = '0, i_req1_val = '0;
   logic             o_req0_ready, o_req1_ready, o_res_valid, o_res_id, o_busy;
   logic [3:0]       o_ones, o_tens, o_hundreds;

   int checks = 0;
   int failures = 0;

   bcd_conv_arbiter #(.WIDTH(WIDTH), .DIGITS(3)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_req0_valid(i_req0_valid), .i_req0_val(i_req0_val), .o_req0_ready(o_req0_ready),
      .i_req1_valid(i_req1_valid), .i_req1_val(i_req1_val), .o_req1_ready(o_req1_ready),
      .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res_id(o_res_id),
      .o_ones(o_ones), .o_tens(o_tens), .o_hundreds(o_hundreds), .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Returns edges until o_res_valid rises, or -1 after 40 edges.
   task automatic wait_valid(output int lat);
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         tick();
         if (o_res_valid) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic pop();
      i_res_ready = 1'b1;
      tick();
      i_res_ready = 1'b0;
      #1;
   endtask

   task automatic apply_reset();
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      tick(); tick();
      checks++;
      if ({o_busy, o_res_valid, o_res_id} !== 3'b000) begin
         failures++;
         $display("FAIL reset_ctrl: got busy/valid/id=%b%b%b expected 000", o_busy, o_res_valid, o_res_id);
      end
      checks++;
      if ({o_hundreds, o_tens, o_ones} !== 12'h000) begin
         failures++;
         $display("FAIL reset_digits: got %h%h%h expected 000", o_hundreds, o_tens, o_ones);
      end
      checks++;
      if ({o_req0_ready, o_req1_ready} !== 2'b00) begin
         failures++;
         $display("FAIL reset_ready: got %b%b expected 00", o_req0_ready, o_req1_ready);
      end
      i_rst = 1'b0;
      tick();
   endtask

   task automatic test_single();
      int lat;
      i_req0_valid = 1'b1; i_req0_val = 8'd255;
      #1;
      checks++;
      if ({o_req0_ready, o_req1_ready} !== 2'b10) begin
         failures++;
         $display("FAIL single_ready: got %b%b expected 10", o_req0_ready, o_req1_ready);
      end
      tick();
      i_req0_valid = 1'b0;
      #1;
      checks++;
      if ({o_busy, o_res_valid, o_req0_ready} !== 3'b100) begin
         failures++;
         $display("FAIL single_conv: got busy/valid/ready=%b%b%b expected 100", o_busy, o_res_valid, o_req0_ready);
      end
      wait_valid(lat);
      checks++;
      if (lat !== WIDTH) begin
         failures++;
         $display("FAIL single_latency: got %0d expected %0d", lat, WIDTH);
      end
      checks++;
      if ({o_res_id, o_hundreds, o_tens, o_ones} !== {1'b0, 12'h255}) begin
         failures++;
         $display("FAIL single_result: got id=%0b %h%h%h expected id=0 255", o_res_id, o_hundreds, o_tens, o_ones);
      end
      pop();
      checks++;
      if ({o_res_valid, o_busy} !== 2'b00) begin
         failures++;
         $display("FAIL single_pop: got valid/busy=%b%b expected 00", o_res_valid, o_busy);
      end
   endtask

   task automatic test_tie();
      int lat;
      apply_reset();
      i_req0_valid = 1'b1; i_req0_val = 8'd123;
      i_req1_valid = 1'b1; i_req1_val = 8'd45;
      #1;
      checks++;
      if ({o_req0_ready, o_req1_ready} !== 2'b10) begin
         failures++;
         $display("FAIL tie_first_grant: got %b%b expected 10", o_req0_ready, o_req1_ready);
      end
      tick();
      i_req0_valid = 1'b0;
      wait_valid(lat);
      checks++;
      if ({o_res_id, o_hundreds, o_tens, o_ones} !== {1'b0, 12'h123} || lat != WIDTH) begin
         failures++;
         $display("FAIL tie_res0: got id=%0b %h%h%h lat=%0d expected id=0 123 lat=%0d", o_res_id, o_hundreds, o_tens, o_ones, lat, WIDTH);
      end
      checks++;
      if (o_req1_ready !== 1'b0) begin
         failures++;
         $display("FAIL tie_done_ready: got %b expected 0", o_req1_ready);
      end
      pop();
      checks++;
      if (o_req1_ready !== 1'b1) begin
         failures++;
         $display("FAIL tie_second_grant: got %b expected 1", o_req1_ready);
      end
      tick();
      i_req1_valid = 1'b0;
      wait_valid(lat);
      checks++;
      if ({o_res_id, o_hundreds, o_tens, o_ones} !== {1'b1, ZB, 8'h45}) begin
         failures++;
         $display("FAIL tie_res1: got id=%0b %h%h%h expected id=1 %h45", o_res_id, o_hundreds, o_tens, o_ones, ZB);
      end
      pop();
   endtask

   task automatic test_backpressure();
      int lat;
      int bad = 0;
      i_req0_valid = 1'b1; i_req0_val = 8'd200;
      tick();
      i_req0_valid = 1'b0;
      wait_valid(lat);
      i_req0_valid = 1'b1; i_req0_val = 8'd50;
      i_req1_valid = 1'b1; i_req1_val = 8'd60;
      #1;
      for (int k = 0; k < 5; k++) begin
         if ({o_res_valid, o_res_id, o_hundreds, o_tens, o_ones, o_req0_ready, o_req1_ready}
             !== {2'b10, 12'h200, 2'b00}) bad++;
         tick();
      end
      checks++;
      if (bad != 0 || lat != WIDTH) begin
         failures++;
         $display("FAIL backpressure_hold: got %0d unstable cycles lat=%0d expected 0 and %0d", bad, lat, WIDTH);
      end
      pop();
      checks++;
      if ({o_res_valid, o_busy, o_req0_ready, o_req1_ready} !== 4'b0001) begin
         failures++;
         $display("FAIL backpressure_release: got valid/busy/r0/r1=%b%b%b%b expected 0001", o_res_valid, o_busy, o_req0_ready, o_req1_ready);
      end
      i_req0_valid = 1'b0; i_req1_valid = 1'b0;
      i_res_ready = 1'b1;
      tick(); tick();
      checks++;
      if ({o_res_valid, o_busy} !== 2'b00) begin
         failures++;
         $display("FAIL stray_res_ready: got valid/busy=%b%b expected 00", o_res_valid, o_busy);
      end
      i_res_ready = 1'b0;
   endtask

   task automatic test_mid_reset();
      int bad = 0;
      i_req0_valid = 1'b1; i_req0_val = 8'd99;
      tick();
      i_req0_valid = 1'b0;
      tick(); tick(); tick();
      checks++;
      if (o_busy !== 1'b1) begin
         failures++;
         $display("FAIL midrst_busy: got %b expected 1", o_busy);
      end
      i_rst = 1'b1;
      tick();
      checks++;
      if ({o_busy, o_res_valid, o_res_id, o_hundreds, o_tens, o_ones} !== 15'h0) begin
         failures++;
         $display("FAIL midrst_outputs: got busy=%b valid=%b id=%b %h%h%h expected all 0", o_busy, o_res_valid, o_res_id, o_hundreds, o_tens, o_ones);
      end
      i_rst = 1'b0;
      i_req0_valid = 1'b1; i_req1_valid = 1'b1;
      #1;
      checks++;
      if ({o_req0_ready, o_req1_ready} !== 2'b10) begin
         failures++;
         $display("FAIL midrst_tie: got %b%b expected 10", o_req0_ready, o_req1_ready);
      end
      i_req0_valid = 1'b0; i_req1_valid = 1'b0;
      for (int k = 0; k < WIDTH + 4; k++) begin
         tick();
         if (o_res_valid || o_busy) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL midrst_no_result: got %0d active cycles expected 0", bad);
      end
   endtask

   task automatic test_values();
      logic [7:0]  vals[3];
      logic [11:0] exp[3];
      int lat;
      vals[0] = 8'd0;   exp[0] = {ZB, ZB, 4'h0};
      vals[1] = 8'd7;   exp[1] = {ZB, ZB, 4'h7};
      vals[2] = 8'd100; exp[2] = 12'h100;
      for (int i = 0; i < 3; i++) begin
         i_req0_valid = 1'b1; i_req0_val = vals[i];
         tick();
         i_req0_valid = 1'b0;
         wait_valid(lat);
         checks++;
         if ({o_hundreds, o_tens, o_ones} !== exp[i] || lat != WIDTH) begin
            failures++;
            $display("FAIL values_%0d: got %h%h%h lat=%0d expected %h lat=%0d", vals[i], o_hundreds, o_tens, o_ones, lat, exp[i], WIDTH);
         end
         pop();
      end
   endtask

   task automatic test_fairness();
      int  acc_cyc[4];
      logic acc_id[4];
      int  na = 0;
      int  nres = 0;
      int  bad = 0;
      logic [11:0] exp;
      apply_reset();
      i_req0_valid = 1'b1; i_req0_val = 8'd11;
      i_req1_valid = 1'b1; i_req1_val = 8'd22;
      i_res_ready = 1'b1;
      #1;
      for (int c = 0; c < 200 && nres < 4; c++) begin
         if ((o_req0_ready || o_req1_ready) && na < 4) begin
            acc_id[na] = o_req1_ready;
            acc_cyc[na] = c;
            na++;
         end
         if (o_res_valid) begin
            exp = (nres % 2 == 0) ? {ZB, 8'h11} : {ZB, 8'h22};
            checks++;
            if ({o_res_id, o_hundreds, o_tens, o_ones} !== {1'(nres % 2), exp}) begin
               failures++;
               $display("FAIL fair_result_%0d: got id=%0b %h%h%h expected id=%0d %h", nres, o_res_id, o_hundreds, o_tens, o_ones, nres % 2, exp);
            end
            nres++;
         end
         tick();
      end
      checks++;
      if (nres != 4 || na != 4) begin
         failures++;
         $display("FAIL fair_timeout: got %0d results %0d accepts expected 4 and 4", nres, na);
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (acc_id[i] !== 1'(i % 2)) bad++;
            if (i > 0 && acc_cyc[i] - acc_cyc[i-1] != WIDTH + 2) bad++;
         end
         if (bad != 0) begin
            failures++;
            $display("FAIL fair_grants: got ids %b%b%b%b gaps %0d/%0d/%0d expected 0101 and %0d", acc_id[0], acc_id[1], acc_id[2], acc_id[3], acc_cyc[1]-acc_cyc[0], acc_cyc[2]-acc_cyc[1], acc_cyc[3]-acc_cyc[2], WIDTH + 2);
         end
      end
      i_req0_valid = 1'b0; i_req1_valid = 1'b0; i_res_ready = 1'b0;
      apply_reset();
   endtask

   initial begin
      test_reset();
      test_single();
      test_tie();
      test_backpressure();
      test_mid_reset();
      test_values();
      test_fairness();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/bcd_conv_arbiter.md
Name: bcd_conv_arbiter

Overview:
- Shares one iterative double-dabble binary-to-BCD engine between two requesters; one add-3/shift step per clock.
- Round-robin arbitration, valid/ready handshake on each request port and on the result port.
- Sits between the counter/score logic and the 7-segment display driver; a sequential, area-cheap alternative to a fully unrolled combinational converter.

Parameters:
- WIDTH, 8, binary input width in bits.
- DIGITS, 3, BCD output digits. Elaboration error unless 10^DIGITS > 2^WIDTH - 1.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- i_req0_valid  in  1  requester 0 has a value.
- i_req0_val  in  WIDTH  requester 0 binary value.
- o_req0_ready  out  1  requester 0 accepted this cycle.
- i_req1_valid  in  1  requester 1 has a value.
- i_req1_val  in  WIDTH  requester 1 binary value.
- o_req1_ready  out  1  requester 1 accepted this cycle.
- o_res_valid  out  1  result available.
- i_res_ready  in  1  consumer takes result.
- o_res_id  out  1  requester that owns the result.
- o_ones  out  4  BCD ones digit.
- o_tens  out  4  BCD tens digit.
- o_hundreds  out  4  BCD hundreds digit (digit 2; DIGITS > 3 digits are internal only).
- o_busy  out  1  state != IDLE.

Behaviour:
- Clocking and reset:
  - One clock, i_clk. Reset i_rst is synchronous and active-high.
  - On reset: state IDLE; o_res_valid, o_res_id, o_ones, o_tens, o_hundreds, o_busy = 0; last_grant = 1, so req0 wins the first tie.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - Grant: only one valid -> that one; both valid -> the one != last_grant.
  - o_reqN_ready is combinational, high only in IDLE, only for the granted N.
  - Accept edge: load shift register {4*DIGITS zeros, value}, latch id, last_grant = id, step counter = WIDTH, go to CONV.
- CONV:
  - Each edge: every 4-bit digit field >= 5 gets +3, then the whole register shifts left 1; counter decrements.
  - When the counter reaches 0, go to DONE and register the digits.
  - Exactly WIDTH cycles in CONV.
- DONE:
  - o_res_valid = 1; digits and id held stable.
  - On an edge with i_res_ready = 1: go to IDLE and clear o_res_valid. Digits keep their value; they are don't-care while invalid.
- Latency and throughput:
  - Accept at edge T -> o_res_valid high after edge T+WIDTH.
  - No same-cycle IDLE re-accept on the result handshake edge; minimum WIDTH+2 cycles per conversion.
- Boundary conditions:
  - Requests arriving in CONV/DONE are not accepted; requesters hold valid and value.
  - A requester dropping valid before its ready is legal; nothing is captured.
  - i_rst mid-CONV or in DONE: conversion discarded, reset values next cycle, no result emitted.
  - Input all-ones (255 at WIDTH=8) must yield 2,5,5; no digit ever exceeds 9.
  - i_res_ready while o_res_valid = 0 is ignored.

Optional Feature:
- Macro BCD_LEADING_ZERO_BLANK_EN.
- Defined:
  - Leading-zero digits are replaced by BCD_BLANK (4'hF) when registered into DONE.
  - o_hundreds blanked if 0.
  - o_tens blanked if o_tens and o_hundreds are both 0.
  - o_ones never blanked.
- Undefined: raw digits are output.
- Timing and handshake are identical either way.

Decomposition:
- Package bcd_pkg:
  - DIGIT_W = 4.
  - BCD_BLANK = 4'hF.
  - FSM state typedef {IDLE, CONV, DONE}.
  - Function computing the minimum DIGITS for a given WIDTH, used by the parameter check.
- Sub-module bcd_dabble_step: purely combinational.
  - Input: (4*DIGITS+WIDTH)-bit register.
  - Output: the register after add-3-if->=5 on each digit, then shift left 1.
  - Instantiated once; the controller owns the FSM, counter, arbitration and output registers.

Test Plan:
1. Single request: req0 val 255 alone -> ready0 1 cycle, o_busy high, o_res_valid after 8 CONV cycles, id 0, digits 2,5,5.
2. Tie after reset: req0 123 and req1 45 both valid -> req0 served first (id 0, 1,2,3), then req1 (id 1, 0,4,5).
3. Backpressure: i_res_ready low 5 cycles in DONE -> outputs stable, both readys low, no new accept; ready high -> IDLE next cycle.
4. Mid-conversion reset: i_rst at CONV step 4 -> next cycle all outputs 0, IDLE; next tie goes to req0.
5. Values 0, 7, 100:
   - Without the macro: 0,0,0 / 0,0,7 / 1,0,0.
   - With BCD_LEADING_ZERO_BLANK_EN: F,F,0 / F,F,7 / 1,0,0.
6. Fairness: req1 held valid continuously, req0 valid continuously -> grants alternate 0,1,0,1 over 4 conversions.
